layer_pipeline_scheduler: RTL



---
 rtl/layer_pipeline_scheduler_pkg.sv | 25 ++
 rtl/layer_pipeline_scheduler_if.sv | 38 +++
 rtl/layer_pipeline_scheduler_counter.sv | 70 +++++++
 rtl/layer_pipeline_scheduler.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/layer_pipeline_scheduler_pkg.sv
// Shared types and helpers for the layer pipeline scheduler.
// - sched_state_t: top-level epoch FSM states.
// - DIM_W: width of one packed dimension field in the LINK_X/Y/C parameters.
// - link_dim(): pulls link k's dimension out of a packed parameter vector.
package dnn_sched_pkg;

    localparam int DIM_W     = 16;
    localparam int MAX_LINKS = 16;
    localparam int PACK_W    = MAX_LINKS * DIM_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_XFER,
        S_ADVANCE,
        S_DONE
    } sched_state_t;

    // Link k occupies bits [DIM_W*k +: DIM_W] of the packed vector.
    function automatic logic [DIM_W-1:0] link_dim(input logic [PACK_W-1:0] dims, input int k);
        return dims[k*DIM_W +: DIM_W];
    endfunction

endpackage

// File: rtl/layer_pipeline_scheduler_if.sv
// Bus between the scheduler, the top-level controller and the per-layer
// compute/memory blocks.
// - master: the scheduler (drives busy/run_done/frames_out, stage starts and
//   link write streams; receives start/num_frames and stage done bits).
// - slave: the environment side (controller + layer blocks).
interface layer_pipeline_scheduler_if #(
    parameter int NUM_STAGES = 5,
    parameter int IDX_W      = 16,
    parameter int LIN_W      = 16,
    parameter int FRAME_W    = 16
);
    localparam int NUM_LINKS = NUM_STAGES - 1;

    logic                        start;
    logic [FRAME_W-1:0]          num_frames;
    logic                        busy;
    logic                        run_done;
    logic [FRAME_W-1:0]          frames_out;
    logic [NUM_STAGES-1:0]       stage_start;
    logic [NUM_STAGES-1:0]       stage_done;
    logic [NUM_LINKS-1:0]        link_wr_en;
    logic [NUM_LINKS*IDX_W-1:0]  link_x;
    logic [NUM_LINKS*IDX_W-1:0]  link_y;
    logic [NUM_LINKS*IDX_W-1:0]  link_c;
    logic [NUM_LINKS*LIN_W-1:0]  link_lin;

    modport master (
        input  start, num_frames, stage_done,
        output busy, run_done, frames_out, stage_start,
               link_wr_en, link_x, link_y, link_c, link_lin
    );

    modport slave (
        output start, num_frames, stage_done,
        input  busy, run_done, frames_out, stage_start,
               link_wr_en, link_x, link_y, link_c, link_lin
    );
endinterface

// File: rtl/layer_pipeline_scheduler_counter.sv
// tensor_index_counter: walks one tensor in x-fastest, then y, then c order.
// Ports:
// - clk, reset (sync, active-high)
// - go: one-cycle pulse, starts a walk at (0,0,0)/lin 0 on the next cycle
// - dim_x, dim_y, dim_c: tensor dimensions
// - x, y, c, lin: registered current index (all 0 while idle)
// - active: high for exactly dim_x*dim_y*dim_c cycles per walk
// - last: high during the final beat of a walk
module tensor_index_counter #(
    parameter int IDX_W = 16,
    parameter int LIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [IDX_W-1:0] dim_x,
    input  logic [IDX_W-1:0] dim_y,
    input  logic [IDX_W-1:0] dim_c,
    output logic [IDX_W-1:0] x,
    output logic [IDX_W-1:0] y,
    output logic [IDX_W-1:0] c,
    output logic [LIN_W-1:0] lin,
    output logic             active,
    output logic             last
);
    logic x_end, y_end, c_end;

    assign x_end = (x == dim_x - 1'b1);
    assign y_end = (y == dim_y - 1'b1);
    assign c_end = (c == dim_c - 1'b1);
    assign last  = active && x_end && y_end && c_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
            c      <= '0;
            lin    <= '0;
        end else if (go) begin
            active <= 1'b1;
            x      <= '0;
            y      <= '0;
            c      <= '0;
            lin    <= '0;
        end else if (active) begin
            if (last) begin
                // Finished: park at zero so idle links present clean indices.
                active <= 1'b0;
                x      <= '0;
                y      <= '0;
                c      <= '0;
                lin    <= '0;
            end else begin
                lin <= lin + 1'b1;
                if (!x_end) begin
                    x <= x + 1'b1;
                end else begin
                    x <= '0;
                    if (!y_end) begin
                        y <= y + 1'b1;
                    end else begin
                        y <= '0;
                        c <= c + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/layer_pipeline_scheduler.sv
// layer_pipeline_scheduler: frame-pipelined epoch scheduler for NUM_STAGES
// lock-step layer stages. Each epoch starts every occupied stage, waits for
// all their done bits, then streams every occupied stage's output into the
// next stage's input memory. Occupancy shifts one stage per epoch, giving
// fill / steady state / drain for a run of num_frames frames.
// Ports:
// - clk, reset (sync, active-high)
// - bus (master modport): start/num_frames in, busy/run_done/frames_out out,
//   stage_start out / stage_done in, per-link wr_en + x/y/c/lin out.
module layer_pipeline_scheduler
    import dnn_sched_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int IDX_W      = 16,
    parameter int LIN_W      = 16,
    parameter int FRAME_W    = 16,
    parameter logic [(NUM_STAGES-1)*DIM_W-1:0] LINK_X = {16'd5, 16'd11, 16'd13, 16'd26},
    parameter logic [(NUM_STAGES-1)*DIM_W-1:0] LINK_Y = {16'd5, 16'd11, 16'd13, 16'd26},
    parameter logic [(NUM_STAGES-1)*DIM_W-1:0] LINK_C = {16'd32, 16'd32, 16'd16, 16'd16}
) (
    input logic                   clk,
    input logic                   reset,
    layer_pipeline_scheduler_if.master bus
);
    localparam int NUM_LINKS = NUM_STAGES - 1;

    sched_state_t          state, state_n;
    logic [NUM_STAGES-1:0] occ, occ_n;
    logic [NUM_STAGES-1:0] pend, pend_n;
    logic [FRAME_W-1:0]    nframes, nframes_n;
    logic [FRAME_W-1:0]    issued, issued_n;
    logic [FRAME_W-1:0]    frames_out, frames_out_n;
    logic                  busy, run_done;
    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_LINKS-1:0]  go, cnt_active, cnt_last;
    logic                  all_done, xfer_end;

    always_comb begin
        state_n      = state;
        occ_n        = occ;
        pend_n       = pend;
        nframes_n    = nframes;
        issued_n     = issued;
        frames_out_n = frames_out;
        go           = '0;
        // Count this cycle's done bits too, so XFER can start right after the last one.
        all_done     = ((pend | (bus.stage_done & occ)) == occ);
        // All links start together; epoch ends once every running link is on its final beat.
        xfer_end     = &(~cnt_active | cnt_last);

        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    nframes_n    = bus.num_frames;
                    frames_out_n = '0;
                    issued_n     = '0;
                    if (bus.num_frames == '0) begin
                        state_n = S_DONE;
                    end else begin
                        occ_n    = NUM_STAGES'(1);
                        issued_n = FRAME_W'(1);
                        state_n  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                pend_n  = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                pend_n = pend | (bus.stage_done & occ);
                if (all_done) begin
                    if (occ[NUM_STAGES-1]) frames_out_n = frames_out + 1'b1;
                    if (occ[NUM_LINKS-1:0] == '0) begin
                        state_n = S_ADVANCE;
                    end else begin
                        state_n = S_XFER;
                        go      = occ[NUM_LINKS-1:0];
                    end
                end
            end
            S_XFER: begin
                if (xfer_end) state_n = S_ADVANCE;
            end
            S_ADVANCE: begin
                occ_n = {occ[NUM_STAGES-2:0], (issued < nframes)};
                if (issued < nframes) issued_n = issued + 1'b1;
                state_n = (occ_n == '0) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            occ         <= '0;
            pend        <= '0;
            nframes     <= '0;
            issued      <= '0;
            frames_out  <= '0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            stage_start <= '0;
        end else begin
            state       <= state_n;
            occ         <= occ_n;
            pend        <= pend_n;
            nframes     <= nframes_n;
            issued      <= issued_n;
            frames_out  <= frames_out_n;
            busy        <= (state_n != S_IDLE);
            run_done    <= (state_n == S_DONE);
            stage_start <= (state_n == S_ISSUE) ? occ_n : '0;
        end
    end

    assign bus.busy        = busy;
    assign bus.run_done    = run_done;
    assign bus.frames_out  = frames_out;
    assign bus.stage_start = stage_start;
    assign bus.link_wr_en  = cnt_active;

    for (genvar k = 0; k < NUM_LINKS; k++) begin : g_link
        localparam logic [IDX_W-1:0] DX = IDX_W'(link_dim(PACK_W'(LINK_X), k));
        localparam logic [IDX_W-1:0] DY = IDX_W'(link_dim(PACK_W'(LINK_Y), k));
        localparam logic [IDX_W-1:0] DC = IDX_W'(link_dim(PACK_W'(LINK_C), k));

        tensor_index_counter #(
            .IDX_W (IDX_W),
            .LIN_W (LIN_W)
        ) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .go     (go[k]),
            .dim_x  (DX),
            .dim_y  (DY),
            .dim_c  (DC),
            .x      (bus.link_x[k*IDX_W +: IDX_W]),
            .y      (bus.link_y[k*IDX_W +: IDX_W]),
            .c      (bus.link_c[k*IDX_W +: IDX_W]),
            .lin    (bus.link_lin[k*LIN_W +: LIN_W]),
            .active (cnt_active[k]),
            .last   (cnt_last[k])
        );
    end
endmodule
